sub_req_arbiter: RTL and testbench

Round-robin arbiter that shares one SUB request channel (REQ/ACK/DAT[7:0]) between N upstream requesters. It sits between the requester blocks and the single SUB instance.
- Selects one pending requester and holds its data on the SUB port until SUB acknowledges.
- Returns the acknowledge to the winning requester and rotates priority.
- A watchdog aborts transfers that SUB never acknowledges.

---
 rtl/sub_req_arbiter_if.sv | 25 ++
 rtl/sub_req_arbiter.sv | 133 +++++++++++++
 tb/tb_sub_req_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_req_arbiter_if.sv
// Signal bundle between the N requesters, the arbiter and the single SUB request port.
// The master view belongs to the arbiter; the slave view to the requesters and SUB side.
interface sub_req_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   REQ_IN;
  logic [8*N-1:0] DAT_IN;
  logic [N-1:0]   ACK_OUT;
  logic           REQ;
  logic           ACK;
  logic [7:0]     DAT;
  logic [2:0]     GNT_ID;
  logic           BUSY;
  logic           TMO_ERR;

  modport master (
    input  REQ_IN, DAT_IN, ACK,
    output ACK_OUT, REQ, DAT, GNT_ID, BUSY, TMO_ERR
  );

  modport slave (
    output REQ_IN, DAT_IN, ACK,
    input  ACK_OUT, REQ, DAT, GNT_ID, BUSY, TMO_ERR
  );
endinterface

// File: rtl/sub_req_arbiter.sv
// Round-robin arbiter sharing one SUB REQ/ACK/DAT channel between N requesters, with an ACK watchdog.
//   state   | meaning
//   S_IDLE  | no transfer, arbitrate over all REQ_IN
//   S_ISSUE | REQ held to SUB, waiting for ACK or watchdog expiry
//   S_GAP   | one-cycle REQ-low gap, arbitrate with last winner masked
module sub_req_arbiter #(
  parameter int N       = 4,
  parameter int TMO_CYC = 255
) (
  input  logic              CLK,
  input  logic              RSTX,
  sub_req_arbiter_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           req_q, req_d;
  logic [7:0]     dat_q, dat_d;
  logic [2:0]     gnt_q, gnt_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [N-1:0]   ack_out_q, ack_out_d;
  logic           tmo_err_q, tmo_err_d;
  logic           busy_q, busy_d;
  logic [15:0]    timer_q, timer_d;

  logic [N-1:0]   arb_req;
  logic           any_req;
  logic [IW-1:0]  win_idx;
  logic [IW-1:0]  scan_idx;
  logic [2:0]     ptr_nxt;
  logic           tmo_hit;

  // Scan from the highest offset down so the lowest offset from PTR is the last one kept.
  always_comb begin : rr_pick
    arb_req = bus.REQ_IN;
    if (state_q == S_GAP) begin
      arb_req = bus.REQ_IN & ~(ONE_HOT0 << gnt_q);
    end
    any_req  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = IW'((int'(ptr_q) + k) % N);
      if (arb_req[scan_idx]) begin
        any_req = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign ptr_nxt = (gnt_q == 3'(N - 1)) ? 3'd0 : gnt_q + 3'd1;
  assign tmo_hit = (TMO_CYC != 0) && (timer_q == 16'(TMO_CYC - 1));

  always_comb begin : fsm_next
    state_d   = state_q;
    req_d     = req_q;
    dat_d     = dat_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    ack_out_d = '0;
    tmo_err_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_GAP: begin
        state_d = S_IDLE;
        if (any_req) begin
          req_d   = 1'b1;
          dat_d   = bus.DAT_IN[{win_idx, 3'b000} +: 8];
          gnt_d   = 3'(win_idx);
          timer_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (timer_q != 16'hFFFF) begin
          timer_d = timer_q + 16'd1;
        end
        // ACK has priority over a watchdog expiry in the same cycle.
        if (bus.ACK) begin
          req_d     = 1'b0;
          ack_out_d = ONE_HOT0 << gnt_q;
          ptr_d     = ptr_nxt;
          state_d   = S_GAP;
        end else if (tmo_hit) begin
          req_d     = 1'b0;
          tmo_err_d = 1'b1;
          ptr_d     = ptr_nxt;
          state_d   = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      dat_q     <= '0;
      gnt_q     <= '0;
      ptr_q     <= '0;
      timer_q   <= '0;
      ack_out_q <= '0;
      tmo_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      dat_q     <= dat_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      ack_out_q <= ack_out_d;
      tmo_err_q <= tmo_err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.REQ     = req_q;
  assign bus.DAT     = dat_q;
  assign bus.GNT_ID  = gnt_q;
  assign bus.ACK_OUT = ack_out_q;
  assign bus.TMO_ERR = tmo_err_q;
  assign bus.BUSY    = busy_q;
endmodule

// File: tb/tb_sub_req_arbiter.sv
// Bench for sub_req_arbiter: per-cycle compare against a transfer-level model,
// plus directed scenarios with hand-derived grant orders, REQ lengths and pulses.
module tb_sub_req_arbiter;
  localparam int N   = 4;
  localparam int TMO = 8;

  logic CLK  = 1'b0;
  logic RSTX = 1'b1;

  sub_req_arbiter_if #(.N(N)) bus ();
  sub_req_arbiter_if #(.N(2)) bus_b ();

  sub_req_arbiter #(.N(N), .TMO_CYC(TMO)) dut   (.CLK(CLK), .RSTX(RSTX), .bus(bus));
  sub_req_arbiter #(.N(2), .TMO_CYC(0))   dut_b (.CLK(CLK), .RSTX(RSTX), .bus(bus_b));

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: an active transfer with an age, a one-cycle gap flag, a pointer.
  bit           m_active = 1'b0;
  bit           m_gap    = 1'b0;
  bit           m_tmo    = 1'b0;
  int           m_age    = 0;
  int           m_gnt    = 0;
  int           m_ptr    = 0;
  int           m_w      = 0;
  logic [1:0]   m_i;
  logic [7:0]   m_dat    = '0;
  logic [N-1:0] m_ackout = '0;

  function automatic logic [7:0] dat_of(input logic [1:0] i);
    return 8'(bus.DAT_IN >> {i, 3'b000});
  endfunction

  initial begin
    forever begin
      @(posedge CLK or negedge RSTX);
      if (!RSTX) begin
        m_active = 1'b0; m_gap = 1'b0; m_tmo = 1'b0; m_age = 0;
        m_gnt = 0; m_ptr = 0; m_dat = '0; m_ackout = '0;
      end else begin
        m_ackout = '0;
        m_tmo    = 1'b0;
        if (m_active) begin
          if (bus.ACK) begin
            m_i = 2'(m_gnt);
            m_ackout[m_i] = 1'b1;
            m_ptr = (m_gnt + 1) % N;
            m_active = 1'b0; m_gap = 1'b1;
          end else if (TMO != 0 && m_age + 1 == TMO) begin
            m_tmo = 1'b1;
            m_ptr = (m_gnt + 1) % N;
            m_active = 1'b0; m_gap = 1'b1;
          end else if (m_age < 65535) begin
            m_age++;
          end
        end else begin
          m_w = -1;
          for (int k = 0; k < N; k++) begin
            m_i = 2'((m_ptr + k) % N);
            if (m_w < 0 && bus.REQ_IN[m_i] && !(m_gap && int'(m_i) == m_gnt)) m_w = int'(m_i);
          end
          m_gap = 1'b0;
          if (m_w >= 0) begin
            m_active = 1'b1; m_age = 0; m_gnt = m_w; m_dat = dat_of(2'(m_w));
          end
        end
      end
    end
  end

  // Compare against the model every cycle, and log grant/REQ-run/pulse history.
  bit         prev_req  = 1'b0;
  int         hi_run    = 0;
  int         low_run   = 0;
  int         last_hi   = 0;
  int         tmo_cnt   = 0;
  int         tmo_b_cnt = 0;
  int         ack_cnt[N];
  int         grants[$];
  int         gdats[$];
  int         gaps[$];
  logic [1:0] mon_i;

  initial begin
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    forever begin
      @(negedge CLK);
      if (RSTX) begin
        check("cmp_req",     32'(bus.REQ),     32'(m_active));
        check("cmp_busy",    32'(bus.BUSY),    32'(m_active | m_gap));
        check("cmp_dat",     32'(bus.DAT),     32'(m_dat));
        check("cmp_gnt",     32'(bus.GNT_ID),  32'(m_gnt));
        check("cmp_ack_out", 32'(bus.ACK_OUT), 32'(m_ackout));
        check("cmp_tmo_err", 32'(bus.TMO_ERR), 32'(m_tmo));
        if (bus.REQ) begin
          if (!prev_req) begin
            grants.push_back(int'(bus.GNT_ID));
            gdats.push_back(int'(bus.DAT));
            gaps.push_back(low_run);
            hi_run = 0;
          end
          hi_run++;
          low_run = 0;
        end else begin
          if (prev_req) last_hi = hi_run;
          low_run++;
        end
        if (bus.TMO_ERR) tmo_cnt++;
        if (bus_b.TMO_ERR) tmo_b_cnt++;
        for (int i = 0; i < N; i++) begin
          mon_i = 2'(i);
          if (bus.ACK_OUT[mon_i]) ack_cnt[i]++;
        end
      end
      prev_req = bus.REQ;
    end
  end

  // SUB responder: ACK after sub_lat cycles of REQ (0 = never), plus a forced stray ACK.
  int sub_lat   = 0;
  bit force_ack = 1'b0;
  int sub_cnt   = 0;

  initial begin
    bus.ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.REQ && sub_lat > 0) begin
        sub_cnt++;
        bus.ACK = (sub_cnt == sub_lat) || force_ack;
      end else begin
        sub_cnt = 0;
        bus.ACK = force_ack;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic int q_at(input int q[$], input int j);
    return (j < q.size()) ? q[j] : -1;
  endfunction

  bit auto_drop = 1'b0;
  int n, base_g, base_tmo, base_a0, base_a1, base_sum;

  task automatic tick();
    logic [1:0] ii;
    @(negedge CLK);
    #1;
    if (auto_drop) begin
      for (int i = 0; i < N; i++) begin
        ii = 2'(i);
        if (bus.ACK_OUT[ii]) bus.REQ_IN[ii] = 1'b0;
      end
    end
  endtask

  initial begin
    bus.REQ_IN   = '0;
    bus.DAT_IN   = '0;
    bus_b.REQ_IN = '0;
    bus_b.DAT_IN = '0;
    bus_b.ACK    = 1'b0;
    #2 RSTX = 1'b0;
    repeat (3) tick();
    check("rst_req",     32'(bus.REQ),     0);
    check("rst_dat",     32'(bus.DAT),     0);
    check("rst_gnt",     32'(bus.GNT_ID),  0);
    check("rst_ack_out", 32'(bus.ACK_OUT), 0);
    check("rst_busy",    32'(bus.BUSY),    0);
    check("rst_tmo_err", 32'(bus.TMO_ERR), 0);
    RSTX = 1'b1;
    repeat (2) tick();

    // Single request, SUB acks 3 cycles after REQ.
    bus.DAT_IN[7:0] = 8'hA5;
    auto_drop = 1'b1;
    sub_lat   = 3;
    base_g    = grants.size();
    base_a0   = ack_cnt[0];
    bus.REQ_IN = 4'b0001;
    n = 0;
    while (!bus.ACK_OUT[0] && n < 50) begin tick(); n++; end
    check("single_done", 32'(n < 50), 1);
    check("single_req_len", 32'(last_hi), 3);
    check("single_gnt", 32'(q_at(grants, base_g)), 0);
    check("single_dat", 32'(q_at(gdats, base_g)), 32'h A5);
    repeat (2) tick();
    check("single_ack_pulses", 32'(ack_cnt[0] - base_a0), 1);
    check("single_idle", 32'(bus.BUSY), 0);

    // Stray ACK while idle is ignored.
    base_sum = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    repeat (2) tick();
    check("stray_ack_busy", 32'(bus.BUSY), 0);
    check("stray_ack_none", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3] - base_sum), 0);

    // Round robin with all four requesting permanently, 1-cycle SUB latency.
    RSTX = 1'b0;
    tick();
    RSTX = 1'b1;
    auto_drop   = 1'b0;
    sub_lat     = 1;
    bus.DAT_IN  = {8'h13, 8'h12, 8'h11, 8'h10};
    base_g      = grants.size();
    bus.REQ_IN  = 4'b1111;
    n = 0;
    while (grants.size() < base_g + 6 && n < 100) begin tick(); n++; end
    bus.REQ_IN = '0;
    check("rr_done", 32'(n < 100), 1);
    for (int j = 0; j < 6; j++) begin
      check("rr_order", 32'(q_at(grants, base_g + j)), 32'(j % 4));
      check("rr_dat", 32'(q_at(gdats, base_g + j)), 32'(8'h10 + j % 4));
      if (j > 0) check("rr_gap_len", 32'(q_at(gaps, base_g + j)), 1);
    end
    n = 0;
    while (bus.BUSY && n < 20) begin tick(); n++; end
    check("rr_settle", 32'(n < 20), 1);

    // Gap masking: requester 2 alone, holds REQ_IN one cycle past ACK_OUT.
    bus.DAT_IN[23:16] = 8'hC3;
    sub_lat = 2;
    base_g  = grants.size();
    bus.REQ_IN = 4'b0100;
    n = 0;
    while (!bus.ACK_OUT[2] && n < 50) begin tick(); n++; end
    check("gap_done", 32'(n < 50), 1);
    tick();
    check("gap_busy", 32'(bus.BUSY), 0);
    check("gap_req", 32'(bus.REQ), 0);
    bus.REQ_IN = '0;
    repeat (3) tick();
    check("gap_ngrants", 32'(grants.size() - base_g), 1);
    check("gap_gnt", 32'(q_at(grants, base_g)), 2);
    check("gap_dat", 32'(q_at(gdats, base_g)), 32'h C3);

    // Timeout on requester 0, then ACK/timeout collision on requester 1.
    auto_drop = 1'b1;
    sub_lat   = 0;
    bus.DAT_IN[7:0]  = 8'h21;
    bus.DAT_IN[15:8] = 8'h22;
    base_g   = grants.size();
    base_tmo = tmo_cnt;
    base_a0  = ack_cnt[0];
    base_a1  = ack_cnt[1];
    bus.REQ_IN = 4'b0011;
    n = 0;
    while (!bus.TMO_ERR && n < 50) begin tick(); n++; end
    check("tmo_done", 32'(n < 50), 1);
    check("tmo_req_len", 32'(last_hi), 8);
    check("tmo_no_ack", 32'(ack_cnt[0] - base_a0), 0);
    check("tmo_gnt", 32'(q_at(grants, base_g)), 0);
    sub_lat = 8;
    n = 0;
    while (!bus.ACK_OUT[1] && n < 50) begin tick(); n++; end
    check("coll_done", 32'(n < 50), 1);
    check("coll_gnt", 32'(q_at(grants, base_g + 1)), 1);
    check("coll_req_len", 32'(last_hi), 8);
    check("coll_no_tmo", 32'(tmo_cnt - base_tmo), 1);
    n = 0;
    while (!bus.ACK_OUT[0] && n < 50) begin tick(); n++; end
    check("retry_done", 32'(n < 50), 1);
    check("retry_gnt", 32'(q_at(grants, base_g + 2)), 0);
    check("retry_dat", 32'(q_at(gdats, base_g + 2)), 32'h 21);
    n = 0;
    while (bus.BUSY && n < 20) begin tick(); n++; end
    check("tmo_settle", 32'(n < 20), 1);

    // Move PTR to 2, then reset mid-transfer and confirm PTR restarts at 0.
    sub_lat = 1;
    bus.REQ_IN = 4'b0010;
    n = 0;
    while ((bus.REQ_IN != 0 || bus.BUSY) && n < 30) begin tick(); n++; end
    check("ptr2_done", 32'(n < 30), 1);
    sub_lat = 0;
    bus.DAT_IN[15:8]  = 8'h31;
    bus.DAT_IN[23:16] = 8'h32;
    bus.REQ_IN = 4'b0110;
    n = 0;
    while (!bus.REQ && n < 20) begin tick(); n++; end
    check("pre_rst_gnt", 32'(bus.GNT_ID), 2);
    check("pre_rst_dat", 32'(bus.DAT), 32'h 32);
    repeat (2) tick();
    RSTX = 1'b0;
    #1;
    check("arst_req",     32'(bus.REQ),     0);
    check("arst_dat",     32'(bus.DAT),     0);
    check("arst_gnt",     32'(bus.GNT_ID),  0);
    check("arst_ack_out", 32'(bus.ACK_OUT), 0);
    check("arst_busy",    32'(bus.BUSY),    0);
    check("arst_tmo_err", 32'(bus.TMO_ERR), 0);
    tick();
    RSTX = 1'b1;
    n = 0;
    while (!bus.REQ && n < 20) begin tick(); n++; end
    check("post_rst_gnt", 32'(bus.GNT_ID), 1);
    check("post_rst_dat", 32'(bus.DAT), 32'h 31);
    sub_lat = 2;
    n = 0;
    while ((bus.REQ_IN != 0 || bus.BUSY) && n < 50) begin tick(); n++; end
    check("post_rst_settle", 32'(n < 50), 1);

    // TMO_CYC = 0 instance: REQ held indefinitely until ACK.
    bus_b.DAT_IN = 16'h5A77;
    bus_b.REQ_IN = 2'b01;
    repeat (40) tick();
    check("notmo_req", 32'(bus_b.REQ), 1);
    check("notmo_busy", 32'(bus_b.BUSY), 1);
    check("notmo_dat", 32'(bus_b.DAT), 32'h 77);
    check("notmo_no_err", 32'(tmo_b_cnt), 0);
    bus_b.ACK = 1'b1;
    tick();
    bus_b.ACK = 1'b0;
    check("notmo_ack_out", 32'(bus_b.ACK_OUT), 32'h1);
    check("notmo_req_drop", 32'(bus_b.REQ), 0);
    bus_b.REQ_IN = '0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
